// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the MEM-stage data-RAM access unit.
package mem_access_pkg;

    localparam logic [1:0] SzByte    = 2'b00;
    localparam logic [1:0] SzHalf    = 2'b01;
    localparam logic [1:0] SzWord    = 2'b10;
    localparam logic [1:0] SzIllegal = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StLdWait,
        StStMerge
    } state_e;

    // True when the byte offset does not satisfy the natural alignment of the size.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SzHalf:  bad = offset[0];
            SzWord:  bad = |offset;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Bit position of the selected lane inside a word (little-endian).
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] offset);
        logic [4:0] sh;
        sh = 5'd0;
        case (size)
            SzByte:  sh = {offset, 3'b000};
            SzHalf:  sh = {offset[1], 4'b0000};
            default: sh = 5'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/load_store_lane.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module load_store_lane
    import mem_access_pkg::*;
#(
    parameter int unsigned NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] word_i,
    input  logic [NB_DATA-1:0] store_data_i,
    input  logic [1:0]         size_i,
    input  logic [1:0]         offset_i,
    input  logic               unsigned_i,
    output logic [NB_DATA-1:0] load_data_o,
    output logic [NB_DATA-1:0] merged_o
);

    logic [4:0]         shift;
    logic [NB_DATA-1:0] shifted;
    logic [NB_DATA-1:0] mask;
    logic               fill_b;
    logic               fill_h;

    // Select the addressed lane, extend it for loads and splice it in for stores.
    always_comb begin
        shift   = lane_shift(size_i, offset_i);
        shifted = word_i >> shift;
        fill_b  = ~unsigned_i & shifted[7];
        fill_h  = ~unsigned_i & shifted[15];
        load_data_o = word_i;
        mask        = '1;
        case (size_i)
            SzByte: begin
                load_data_o = {{(NB_DATA-8){fill_b}}, shifted[7:0]};
                mask        = {{(NB_DATA-8){1'b0}}, 8'hFF} << shift;
            end
            SzHalf: begin
                load_data_o = {{(NB_DATA-16){fill_h}}, shifted[15:0]};
                mask        = {{(NB_DATA-16){1'b0}}, 16'hFFFF} << shift;
            end
            default: begin
                load_data_o = word_i;
                mask        = '1;
            end
        endcase
        merged_o = (word_i & ~mask) | ((store_data_i << shift) & mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the 1-cycle-latency data RAM: loads, stores, sub-word RMW.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 11
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [1:0]         i_size,
    input  logic               i_unsigned,
    input  logic [31:0]        i_address,
    input  logic [NB_DATA-1:0] i_write_data,
    output logic               o_ready,
    output logic [NB_DATA-1:0] o_read_data,
    output logic               o_read_valid,
    output logic               o_error,
    output logic [NB_ADDR-1:0] o_ram_addra,
    output logic [NB_DATA-1:0] o_ram_dina,
    output logic               o_ram_wea,
    output logic               o_ram_ena,
    output logic               o_ram_regcea,
    input  logic [NB_DATA-1:0] i_ram_douta
);

    state_e             state_q, state_d;
    logic [1:0]         size_q, offset_q;
    logic               unsigned_q;
    logic [NB_DATA-1:0] wdata_q;
    logic [NB_ADDR-1:0] addr_q;
    logic [NB_DATA-1:0] read_data_q;
    logic               read_valid_q, error_q;

    logic               req_seen, req_err, accept;
    logic               latch_req, load_capture;
    logic [NB_DATA-1:0] lane_load, lane_merged;
    logic [NB_ADDR-1:0] req_addr;
    logic               unused_addr;

    assign req_addr     = i_address[NB_ADDR+1:2];
    // Upper address bits wrap away by design.
    assign unused_addr  = ^i_address[31:NB_ADDR+2];
    assign o_ready      = (state_q == StIdle);
    assign o_ram_regcea = 1'b1;
    assign o_read_data  = read_data_q;
    assign o_read_valid = read_valid_q;
    assign o_error      = error_q;
    assign req_seen     = i_valid & o_ready & ~i_reset;

    // Classify the incoming request: error, accepted, or no-op.
    always_comb begin
        req_err = 1'b0;
        if (i_mem_read & i_mem_write) begin
            req_err = 1'b1;
        end else if (i_mem_read | i_mem_write) begin
            req_err = (i_size == SzIllegal) | misaligned(i_size, i_address[1:0]);
        end
        req_err = req_err & req_seen;
        accept  = req_seen & (i_mem_read ^ i_mem_write) & ~req_err;
    end

    load_store_lane #(
        .NB_DATA(NB_DATA)
    ) u_lane (
        .word_i      (i_ram_douta),
        .store_data_i(wdata_q),
        .size_i      (size_q),
        .offset_i    (offset_q),
        .unsigned_i  (unsigned_q),
        .load_data_o (lane_load),
        .merged_o    (lane_merged)
    );

    // Next-state and RAM port drive; RAM port is quiet while reset is held.
    always_comb begin
        state_d      = state_q;
        o_ram_ena    = 1'b0;
        o_ram_wea    = 1'b0;
        o_ram_addra  = '0;
        o_ram_dina   = '0;
        latch_req    = 1'b0;
        load_capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    o_ram_ena   = 1'b1;
                    o_ram_addra = req_addr;
                    if (i_mem_write && i_size == SzWord) begin
                        o_ram_wea  = 1'b1;
                        o_ram_dina = i_write_data;
                    end else begin
                        latch_req = 1'b1;
                        state_d   = i_mem_read ? StLdWait : StStMerge;
                    end
                end
            end
            StLdWait: begin
                load_capture = 1'b1;
                state_d      = StIdle;
            end
            StStMerge: begin
                o_ram_ena   = 1'b1;
                o_ram_wea   = 1'b1;
                o_ram_addra = addr_q;
                o_ram_dina  = lane_merged;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (i_reset) begin
            o_ram_ena   = 1'b0;
            o_ram_wea   = 1'b0;
            o_ram_addra = '0;
            o_ram_dina  = '0;
        end
    end

    // State, request latches and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= StIdle;
            size_q       <= SzByte;
            offset_q     <= 2'b00;
            unsigned_q   <= 1'b0;
            wdata_q      <= '0;
            addr_q       <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            read_valid_q <= load_capture;
            error_q      <= req_err;
            if (load_capture) begin
                read_data_q <= lane_load;
            end
            if (latch_req) begin
                size_q     <= i_size;
                offset_q   <= i_address[1:0];
                unsigned_q <= i_unsigned;
                wdata_q    <= i_write_data;
                addr_q     <= req_addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: behavioural RAM plus a byte-array reference model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid, mem_read, mem_write, uns;
    logic [1:0]  size;
    logic [31:0] address, wdata;
    logic        ready, read_valid, error;
    logic [31:0] read_data;
    logic [10:0] ram_addra;
    logic [31:0] ram_dina, ram_douta;
    logic        ram_wea, ram_ena, ram_regcea;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] ram        [0:2047];
    logic [31:0] init_words [0:2047];
    logic        init_req;
    logic [7:0]  ref_bytes  [0:8191];
    logic        wea_bad;

    mem_access_unit #(
        .NB_DATA(32),
        .NB_ADDR(11)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_valid     (valid),
        .i_mem_read  (mem_read),
        .i_mem_write (mem_write),
        .i_size      (size),
        .i_unsigned  (uns),
        .i_address   (address),
        .i_write_data(wdata),
        .o_ready     (ready),
        .o_read_data (read_data),
        .o_read_valid(read_valid),
        .o_error     (error),
        .o_ram_addra (ram_addra),
        .o_ram_dina  (ram_dina),
        .o_ram_wea   (ram_wea),
        .o_ram_ena   (ram_ena),
        .o_ram_regcea(ram_regcea),
        .i_ram_douta (ram_douta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 2048; i++) ram[i] <= init_words[i];
        end else if (ram_ena) begin
            if (ram_wea) ram[ram_addra] <= ram_dina;
            ram_douta <= ram[ram_addra];
        end
    end

    always @(negedge clk) if (ram_wea && !ram_ena) wea_bad <= 1'b1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic void model_store(input logic [1:0] sz, input logic [31:0] addr,
                                        input logic [31:0] data);
        int a  = int'(addr[12:0]);
        int nb = 1 << sz;
        for (int k = 0; k < nb; k++) ref_bytes[a + k] = data[8*k +: 8];
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        int a = int'({addr[12:2], 2'b00});
        return {ref_bytes[a+3], ref_bytes[a+2], ref_bytes[a+1], ref_bytes[a]};
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u,
                                               input logic [31:0] addr);
        int a  = int'(addr[12:0]);
        int nb = 1 << sz;
        logic [31:0] v = 0;
        int s;
        for (int k = 0; k < nb; k++) v = v | (32'(ref_bytes[a + k]) << (8 * k));
        if (u || sz == SzWord) return v;
        if (sz == SzByte) s = $signed(v[7:0]);
        else              s = $signed(v[15:0]);
        return s;
    endfunction

    // ---------------- drive helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        valid = 0; mem_read = 0; mem_write = 0; size = 0; uns = 0; address = 0; wdata = 0;
    endtask

    task automatic junk_req();
        valid     = 1;
        mem_read  = 1'($urandom_range(0, 1));
        mem_write = ~mem_read;
        size      = 2'($urandom_range(0, 2));
        uns       = 1'($urandom_range(0, 1));
        address   = $urandom;
        wdata     = $urandom;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 16) begin
            step();
            n++;
        end
        tests_run++;
        if (ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL wait_ready: got ready=%b required 1 within 16 cycles", ready);
        end
    endtask

    task automatic do_load(input logic [1:0] sz, input logic u, input logic [31:0] addr,
                           output logic [31:0] got);
        logic [31:0] exp;
        wait_ready();
        exp = model_load(sz, u, addr);
        valid = 1; mem_read = 1; mem_write = 0; size = sz; uns = u; address = addr;
        wdata = $urandom;
        @(negedge clk);
        tests_run++;
        if (!(ram_ena === 1 && ram_wea === 0 && ram_addra === addr[12:2])) begin
            tests_failed++;
            $display("FAIL ld_issue @%h: got ena=%b wea=%b addra=%h required 1 0 %h",
                     addr, ram_ena, ram_wea, ram_addra, addr[12:2]);
        end
        step();
        junk_req();
        @(negedge clk);
        tests_run++;
        if (!(ready === 0 && read_valid === 0 && ram_ena === 0)) begin
            tests_failed++;
            $display("FAIL ld_wait @%h: got ready=%b rvalid=%b ena=%b required 0 0 0",
                     addr, ready, read_valid, ram_ena);
        end
        step();
        clear_req();
        @(negedge clk);
        tests_run++;
        if (!(read_valid === 1 && read_data === exp && ready === 1)) begin
            tests_failed++;
            $display("FAIL ld_data sz=%0d u=%b @%h: got rvalid=%b data=%h ready=%b required 1 %h 1",
                     sz, u, addr, read_valid, read_data, ready, exp);
        end
        got = read_data;
        step();
    endtask

    task automatic do_store(input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] data);
        logic [31:0] exp_word;
        wait_ready();
        model_store(sz, addr, data);
        exp_word = model_word(addr);
        valid = 1; mem_read = 0; mem_write = 1; size = sz; uns = 1'($urandom_range(0, 1));
        address = addr; wdata = data;
        @(negedge clk);
        if (sz == SzWord) begin
            tests_run++;
            if (!(ram_ena === 1 && ram_wea === 1 && ram_addra === addr[12:2]
                  && ram_dina === exp_word && ready === 1)) begin
                tests_failed++;
                $display("FAIL sw_issue @%h: got ena=%b wea=%b addra=%h dina=%h ready=%b required 1 1 %h %h 1",
                         addr, ram_ena, ram_wea, ram_addra, ram_dina, ready, addr[12:2], exp_word);
            end
            step();
            clear_req();
        end else begin
            tests_run++;
            if (!(ram_ena === 1 && ram_wea === 0 && ram_addra === addr[12:2])) begin
                tests_failed++;
                $display("FAIL st_read @%h: got ena=%b wea=%b addra=%h required 1 0 %h",
                         addr, ram_ena, ram_wea, ram_addra, addr[12:2]);
            end
            step();
            junk_req();
            @(negedge clk);
            tests_run++;
            if (!(ready === 0 && ram_ena === 1 && ram_wea === 1 && ram_addra === addr[12:2]
                  && ram_dina === exp_word)) begin
                tests_failed++;
                $display("FAIL st_merge sz=%0d @%h: got ready=%b ena=%b wea=%b addra=%h dina=%h required 0 1 1 %h %h",
                         sz, addr, ready, ram_ena, ram_wea, ram_addra, ram_dina, addr[12:2], exp_word);
            end
            step();
            clear_req();
            @(negedge clk);
            tests_run++;
            if (!(ready === 1 && ram_ena === 0)) begin
                tests_failed++;
                $display("FAIL st_done @%h: got ready=%b ena=%b required 1 0", addr, ready, ram_ena);
            end
            step();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; clear_req();
        for (int i = 0; i < 2048; i++) begin
            init_words[i] = $urandom;
            for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = init_words[i][8*k +: 8];
        end
        init_req = 1;
        step();
        init_req = 0;
        step();
        step();
        rst = 0;
        @(negedge clk);
        tests_run++;
        if (!(ready === 1 && read_valid === 0 && error === 0 && read_data === 0)) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ready=%b rvalid=%b err=%b data=%h required 1 0 0 0",
                     ready, read_valid, error, read_data);
        end
        tests_run++;
        if (!(ram_ena === 0 && ram_wea === 0 && ram_addra === 0 && ram_dina === 0
              && ram_regcea === 1)) begin
            tests_failed++;
            $display("FAIL reset_ram: got ena=%b wea=%b addra=%h dina=%h regcea=%b required 0 0 0 0 1",
                     ram_ena, ram_wea, ram_addra, ram_dina, ram_regcea);
        end
        step();
    endtask

    task automatic test_directed();
        logic [31:0] got, r;
        do_store(SzWord, 32'h10, 32'h11223344);
        do_load(SzWord, 0, 32'h10, got);
        tests_run++;
        if (got !== 32'h11223344) begin
            tests_failed++;
            $display("FAIL lw_const: got %h required 11223344", got);
        end
        do_load(SzByte, 0, 32'h13, got);
        tests_run++;
        if (got !== 32'h00000011) begin
            tests_failed++;
            $display("FAIL lb_13: got %h required 00000011", got);
        end
        r = $urandom;
        do_store(SzByte, 32'h12, {r[31:8], 8'h80});
        do_load(SzByte, 0, 32'h12, got);
        tests_run++;
        if (got !== 32'hFFFFFF80) begin
            tests_failed++;
            $display("FAIL lb_sign: got %h required FFFFFF80", got);
        end
        do_load(SzByte, 1, 32'h12, got);
        tests_run++;
        if (got !== 32'h00000080) begin
            tests_failed++;
            $display("FAIL lbu_zero: got %h required 00000080", got);
        end
        do_store(SzWord, 32'h10, 32'h11223344);
        r = $urandom;
        do_store(SzHalf, 32'h12, {r[31:16], 16'hBEEF});
        do_load(SzWord, 0, 32'h10, got);
        tests_run++;
        if (got !== 32'hBEEF3344) begin
            tests_failed++;
            $display("FAIL sh_merge: got %h required BEEF3344", got);
        end
    endtask

    task automatic test_errors();
        // {read, write, size, address}
        logic [35:0] cases [4];
        cases[0] = {1'b1, 1'b0, SzWord, 32'h0000_0002};
        cases[1] = {1'b0, 1'b1, SzHalf, 32'h0000_0001};
        cases[2] = {1'b1, 1'b0, SzIllegal, 32'h0000_0020};
        cases[3] = {1'b1, 1'b1, SzWord, 32'h0000_0020};
        for (int i = 0; i < 4; i++) begin
            wait_ready();
            valid = 1; mem_read = cases[i][35]; mem_write = cases[i][34];
            size = cases[i][33:32]; address = cases[i][31:0]; uns = 0; wdata = $urandom;
            @(negedge clk);
            tests_run++;
            if (!(ram_ena === 0 && ram_wea === 0 && ready === 1)) begin
                tests_failed++;
                $display("FAIL err_issue case %0d: got ena=%b wea=%b ready=%b required 0 0 1",
                         i, ram_ena, ram_wea, ready);
            end
            step();
            clear_req();
            @(negedge clk);
            tests_run++;
            if (!(error === 1 && ram_ena === 0 && ready === 1)) begin
                tests_failed++;
                $display("FAIL err_pulse case %0d: got err=%b ena=%b ready=%b required 1 0 1",
                         i, error, ram_ena, ready);
            end
            step();
            @(negedge clk);
            tests_run++;
            if (error !== 0) begin
                tests_failed++;
                $display("FAIL err_clear case %0d: got err=%b required 0", i, error);
            end
            step();
        end
        // valid with neither read nor write is a quiet no-op
        valid = 1; size = SzWord; address = 32'h3;
        @(negedge clk);
        step();
        clear_req();
        @(negedge clk);
        tests_run++;
        if (!(error === 0 && ram_ena === 0 && ready === 1)) begin
            tests_failed++;
            $display("FAIL noop: got err=%b ena=%b ready=%b required 0 0 1", error, ram_ena, ready);
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] got, r;
        wait_ready();
        r = $urandom;
        valid = 1; mem_read = 0; mem_write = 1; size = SzHalf; uns = 0;
        address = 32'h40; wdata = r;
        step();
        rst = 1;
        clear_req();
        @(negedge clk);
        tests_run++;
        if (!(ram_wea === 0 && ram_ena === 0)) begin
            tests_failed++;
            $display("FAIL rst_merge_wea: got ena=%b wea=%b required 0 0", ram_ena, ram_wea);
        end
        step();
        rst = 0;
        @(negedge clk);
        tests_run++;
        if (!(ready === 1 && read_valid === 0 && error === 0 && read_data === 0
              && ram_ena === 0 && ram_wea === 0 && ram_dina === 0 && ram_addra === 0)) begin
            tests_failed++;
            $display("FAIL rst_merge_out: got ready=%b rvalid=%b err=%b data=%h ena=%b wea=%b required 1 0 0 0 0 0",
                     ready, read_valid, error, read_data, ram_ena, ram_wea);
        end
        step();
        do_load(SzWord, 0, 32'h40, got);
        // Reset while a load is in flight drops it.
        wait_ready();
        valid = 1; mem_read = 1; mem_write = 0; size = SzWord; address = 32'h44;
        step();
        rst = 1;
        clear_req();
        step();
        rst = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if (read_valid !== 0) begin
                tests_failed++;
                $display("FAIL rst_load_drop cycle %0d: got rvalid=%b required 0", c, read_valid);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_val, b_val, exp_lh;
        a_val = $urandom;
        b_val = $urandom;
        wait_ready();
        valid = 1; mem_read = 0; mem_write = 1; size = SzWord; uns = 0;
        address = 32'h2010; wdata = a_val;
        @(negedge clk);
        tests_run++;
        if (!(ram_wea === 1 && ram_addra === 11'd4 && ram_dina === a_val)) begin
            tests_failed++;
            $display("FAIL b2b_sw1: got wea=%b addra=%h dina=%h required 1 004 %h",
                     ram_wea, ram_addra, ram_dina, a_val);
        end
        step();
        model_store(SzWord, 32'h2010, a_val);
        address = 32'h14; wdata = b_val;
        @(negedge clk);
        tests_run++;
        if (!(ready === 1 && ram_wea === 1 && ram_addra === 11'd5 && ram_dina === b_val)) begin
            tests_failed++;
            $display("FAIL b2b_sw2: got ready=%b wea=%b addra=%h dina=%h required 1 1 005 %h",
                     ready, ram_wea, ram_addra, ram_dina, b_val);
        end
        step();
        model_store(SzWord, 32'h14, b_val);
        exp_lh = model_load(SzHalf, 0, 32'h16);
        mem_read = 1; mem_write = 0; address = 32'h10;
        @(negedge clk);
        tests_run++;
        if (!(ram_ena === 1 && ram_wea === 0 && ram_addra === 11'd4)) begin
            tests_failed++;
            $display("FAIL b2b_lw_issue: got ena=%b wea=%b addra=%h required 1 0 004",
                     ram_ena, ram_wea, ram_addra);
        end
        step();
        clear_req();
        step();
        tests_run++;
        if (ready !== 1) begin
            tests_failed++;
            $display("FAIL b2b_ready_n2: got ready=%b required 1", ready);
        end
        valid = 1; mem_read = 1; size = SzHalf; uns = 0; address = 32'h16;
        @(negedge clk);
        tests_run++;
        if (!(read_valid === 1 && read_data === a_val && ram_ena === 1 && ram_addra === 11'd5)) begin
            tests_failed++;
            $display("FAIL b2b_lw_data: got rvalid=%b data=%h ena=%b addra=%h required 1 %h 1 005",
                     read_valid, read_data, ram_ena, ram_addra, a_val);
        end
        step();
        clear_req();
        step();
        @(negedge clk);
        tests_run++;
        if (!(read_valid === 1 && read_data === exp_lh)) begin
            tests_failed++;
            $display("FAIL b2b_lh_data: got rvalid=%b data=%h required 1 %h",
                     read_valid, read_data, exp_lh);
        end
        step();
    endtask

    task automatic test_random();
        logic [31:0] got, addr;
        logic [1:0]  sz;
        logic [1:0]  off;
        for (int i = 0; i < 40; i++) begin
            sz  = 2'($urandom_range(0, 2));
            off = 2'($urandom_range(0, 3));
            if (sz == SzHalf) off[0] = 1'b0;
            if (sz == SzWord) off = 2'b00;
            addr = ($urandom & 32'hFFFF_E000) | (32'($urandom_range(0, 15)) << 2) | 32'(off);
            if ($urandom_range(0, 1) == 1) do_store(sz, addr, $urandom);
            else do_load(sz, 1'($urandom_range(0, 1)), addr, got);
        end
    endtask

    task automatic test_wea_ena();
        tests_run++;
        if (wea_bad !== 0) begin
            tests_failed++;
            $display("FAIL wea_without_ena: got flag=%b required 0", wea_bad);
        end
    endtask

    initial begin
        wea_bad  = 0;
        init_req = 0;
        rst      = 1;
        clear_req();
        test_reset();
        test_directed();
        test_errors();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        test_wea_ena();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
